// File: rtl/serial_adder_ctrl_if.sv
// Request/response bundle for the bit-serial adder controller.
// The master drives operands and the start strobe; the slave returns status and result.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell plus a carry flop, reused over WIDTH clocks.
// Operands are shifted LSB-first; result bits enter the sum register at the MSB end.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] sum_q;
  logic [CntW-1:0]  count_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;

  logic sum_bit;
  logic carry_nxt;

  // Full-adder cell fed by the operand LSBs and the carry flop.
  always_comb begin
    sum_bit   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  end

  // Control FSM with datapath and registered status outputs; rst wins in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sr_q  <= bus.a_in;
            b_sr_q  <= bus.b_in;
            carry_q <= bus.cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          sum_q   <= {sum_bit, sum_q[WIDTH-1:1]};
          carry_q <= carry_nxt;
          a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          count_q <= count_q + CntW'(1);
          // Last bit goes through the cell on this edge.
          if (count_q == CntW'(WIDTH - 1)) begin
            cout_q  <= carry_nxt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=3.
// Drivers push the arithmetic result a+b+cin with the acceptance cycle; monitors pop on done.
module tb_serial_adder_ctrl;

  typedef struct {
    logic [8:0] res;
    int         c0;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   tests;
  int   fails;
  int   busy_cnt8;
  int   busy_cnt3;
  exp_t q8[$];
  exp_t q3[$];

  serial_adder_ctrl_if #(.WIDTH(8)) if8 ();
  serial_adder_ctrl_if #(.WIDTH(3)) if3 ();

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  serial_adder_ctrl #(.WIDTH(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (if8.busy) busy_cnt8++;
    if (if8.done) begin
      if (q8.size() == 0) begin
        check("w8 spurious done", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        check("w8 {cout,sum}", {23'd0, if8.cout, if8.sum}, {23'd0, e.res});
        check("w8 done latency", cyc - e.c0, 32'd8);
        check("w8 busy cycles", busy_cnt8, 32'd8);
      end
      busy_cnt8 = 0;
    end
  end

  // Monitor for the 3-bit instance.
  always @(negedge clk) begin
    exp_t e;
    if (if3.busy) busy_cnt3++;
    if (if3.done) begin
      if (q3.size() == 0) begin
        check("w3 spurious done", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        check("w3 {cout,sum}", {28'd0, if3.cout, if3.sum}, {23'd0, e.res});
        check("w3 done latency", cyc - e.c0, 32'd3);
        check("w3 busy cycles", busy_cnt3, 32'd3);
      end
      busy_cnt3 = 0;
    end
  end

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c);
    exp_t e;
    @(negedge clk);
    if8.a_in  = a;
    if8.b_in  = b;
    if8.cin   = c;
    if8.start = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    e.res = 9'(a) + 9'(b) + 9'(c);
    e.c0  = cyc;
    q8.push_back(e);
  endtask

  task automatic wait_done8();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (if8.done) seen = 1'b1;
    end
    if (!seen) check("w8 done timeout", 32'd0, 32'd1);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    start8(a, b, c);
    wait_done8();
  endtask

  task automatic send3(input logic [2:0] a, input logic [2:0] b, input logic c);
    exp_t e;
    bit   seen;
    @(negedge clk);
    if3.a_in  = a;
    if3.b_in  = b;
    if3.cin   = c;
    if3.start = 1'b1;
    @(posedge clk);
    #1 if3.start = 1'b0;
    e.res = 9'(a) + 9'(b) + 9'(c);
    e.c0  = cyc;
    q3.push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (if3.done) seen = 1'b1;
    end
    if (!seen) check("w3 done timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    tests     = 0;
    fails     = 0;
    cyc       = 0;
    busy_cnt8 = 0;
    busy_cnt3 = 0;
    if8.start = 1'b0;
    if8.a_in  = '0;
    if8.b_in  = '0;
    if8.cin   = 1'b0;
    if3.start = 1'b0;
    if3.a_in  = '0;
    if3.b_in  = '0;
    if3.cin   = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst busy", {31'd0, if8.busy}, 32'd0);
    check("rst done", {31'd0, if8.done}, 32'd0);
    check("rst sum", {24'd0, if8.sum}, 32'd0);
    check("rst cout", {31'd0, if8.cout}, 32'd0);
    check("rst w3 sum/cout", {28'd0, if3.cout, if3.sum}, 32'd0);

    // Directed cases.
    send8(8'h0F, 8'h01, 1'b0);
    send8(8'hFF, 8'h01, 1'b0);
    repeat (5) @(negedge clk);
    check("held sum", {24'd0, if8.sum}, 32'h00);
    check("held cout", {31'd0, if8.cout}, 32'd1);
    send8(8'h00, 8'h00, 1'b1);
    send8(8'hFF, 8'hFF, 1'b1);

    // Start re-asserted mid-SHIFT must be ignored.
    start8(8'h12, 8'h34, 1'b0);
    repeat (2) @(negedge clk);
    if8.a_in  = 8'hFF;
    if8.b_in  = 8'hFF;
    if8.cin   = 1'b1;
    if8.start = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    wait_done8();
    repeat (12) @(negedge clk);
    check("ignored start leaves sum", {23'd0, if8.cout, if8.sum}, 32'h046);

    // Reset in the middle of SHIFT discards the transaction.
    start8(8'hA5, 8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q8.delete();
    busy_cnt8 = 0;
    @(negedge clk);
    check("mid rst busy", {31'd0, if8.busy}, 32'd0);
    check("mid rst sum", {24'd0, if8.sum}, 32'd0);
    check("mid rst cout", {31'd0, if8.cout}, 32'd0);
    check("mid rst done", {31'd0, if8.done}, 32'd0);
    repeat (12) @(negedge clk);
    send8(8'h3C, 8'h44, 1'b0);

    // Randomized back-to-back and gapped traffic.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send8(ra, rb, 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Exhaustive sweep of the 3-bit instance.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          send3(3'(a), 3'(b), 1'(c));
        end
      end
    end

    repeat (4) @(negedge clk);
    check("w8 queue drained", q8.size(), 32'd0);
    check("w3 queue drained", q3.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
